// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: accepts md ops from E, runs a fixed busy period,
// commits results to HI/LO and stalls HI/LO users in E while the unit is busy.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        E_md_use,
    input  logic        Req,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pending_hi;
    logic [31:0]      pending_lo;
    logic             pending_wr;
    logic             op_valid;
    logic             go;
    logic [63:0]      md_result;

    // Results are packed as {hi, lo}.
    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        ae = 64'(a);
        be = 64'(b);
        return ae * be;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Divide magnitudes then restore signs; this also makes 0x80000000 / -1 wrap to 0x80000000.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) r = ~r + 32'd1;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    assign op_valid = (md_op >= OP_MULT) && (md_op <= OP_MTLO);
    assign go       = start & ~Req & ~busy & op_valid;
    assign stall_md = E_md_use & busy;

    always_comb begin
        md_result = '0;
        case (md_op)
            OP_MULT:  md_result = mul_signed(rs_val, rt_val);
            OP_MULTU: md_result = mul_unsigned(rs_val, rt_val);
            OP_DIV:   md_result = div_signed(rs_val, rt_val);
            OP_DIVU:  md_result = div_unsigned(rs_val, rt_val);
            default:  md_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cnt        <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_wr <= 1'b0;
            HI         <= '0;
            LO         <= '0;
        end else if (state == ST_RUN) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                if (pending_wr) begin
                    HI <= pending_hi;
                    LO <= pending_lo;
                end
                state <= ST_IDLE;
                busy  <= 1'b0;
            end
        end else if (go) begin
            case (md_op)
                OP_MTHI: HI <= rs_val;
                OP_MTLO: LO <= rs_val;
                OP_MULT, OP_MULTU: begin
                    pending_hi <= md_result[63:32];
                    pending_lo <= md_result[31:0];
                    pending_wr <= 1'b1;
                    cnt        <= MULT_LOAD;
                    state      <= ST_RUN;
                    busy       <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    // A zero divisor still occupies the unit but commits nothing.
                    pending_hi <= md_result[63:32];
                    pending_lo <= md_result[31:0];
                    pending_wr <= (rt_val != 32'd0);
                    cnt        <= DIV_LOAD;
                    state      <= ST_RUN;
                    busy       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: directed scenarios plus randomized ops against a
// cycle-level reference model built on 64-bit integer arithmetic.
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        E_md_use = 1'b0;
    logic        Req = 1'b0;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .E_md_use(E_md_use),
        .Req     (Req),
        .busy    (busy),
        .stall_md(stall_md),
        .HI      (HI),
        .LO      (LO)
    );

    // Reference model: remaining busy cycles plus the result due at the end of them.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;
    bit          m_pv = 1'b0;
    int          m_left = 0;
    longint      ma, mb, mq, mr, mp;
    logic [63:0] mpv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pv = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pv) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (start && !Req && md_op >= 3'd1 && md_op <= 3'd6) begin
            case (md_op)
                3'd1: begin
                    ma = longint'($signed(rs_val)); mb = longint'($signed(rt_val));
                    mp = ma * mb; mpv = mp;
                    m_phi = mpv[63:32]; m_plo = mpv[31:0]; m_pv = 1'b1; m_left = MULT_N;
                end
                3'd2: begin
                    mpv = {32'd0, rs_val} * {32'd0, rt_val};
                    m_phi = mpv[63:32]; m_plo = mpv[31:0]; m_pv = 1'b1; m_left = MULT_N;
                end
                3'd3, 3'd4: begin
                    if (md_op == 3'd3) begin
                        ma = longint'($signed(rs_val)); mb = longint'($signed(rt_val));
                    end else begin
                        ma = longint'({32'd0, rs_val}); mb = longint'({32'd0, rt_val});
                    end
                    m_pv = (rt_val != 32'd0);
                    if (m_pv) begin
                        mq = ma / mb; mr = ma % mb;
                        m_plo = mq[31:0]; m_phi = mr[31:0];
                    end
                    m_left = DIV_N;
                end
                3'd5: m_hi = rs_val;
                default: m_lo = rs_val;
            endcase
        end
    end

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_hl, input logic rq);
        @(negedge clk);
        start = s; md_op = op; rs_val = a; rt_val = b; E_md_use = use_hl; Req = rq;
        #1;
    endtask

    task automatic idle(input logic use_hl);
        drive(1'b0, 3'd0, 32'd0, 32'd0, use_hl, 1'b0);
    endtask

    task automatic test_reset();
        E_md_use = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_md); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
        @(negedge clk);
        reset = 1'b0;
        E_md_use = 1'b0;
    endtask

    task automatic test_mult();
        logic exp;
        drive(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i <= MULT_N; i++) begin
            idle(1'b0);
            exp = (i < MULT_N);
            checks++; if (busy !== exp) begin errors++; $display("FAIL mult_busy[%0d]: got %b want %b", i, busy, exp); end
        end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_divu_stall();
        logic exp;
        drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL divu_issue_stall: got %b want 0", stall_md); end
        for (int i = 0; i <= DIV_N; i++) begin
            idle(1'b1);
            exp = (i < DIV_N);
            checks++; if (stall_md !== exp) begin errors++; $display("FAIL divu_stall[%0d]: got %b want %b", i, stall_md, exp); end
        end
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", LO); end
        checks++; if (HI !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", HI); end
    endtask

    task automatic test_div_signed();
        drive(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        repeat (DIV_N + 1) idle(1'b0);
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", HI); end
        drive(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        repeat (DIV_N + 1) idle(1'b0);
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
    endtask

    task automatic test_req();
        int seen;
        drive(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        seen = 0;
        repeat (MULT_N + 2) begin
            idle(1'b0);
            if (busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL req_victim_busy: got %0d busy cycles want 0", seen); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL req_victim_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL req_victim_lo: got %h want 80000000", LO); end
        // DIV accepted at t, Req (with a would-be MTHI) at t+2, commit visible at t+11
        drive(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1, 1'b1);
        repeat (DIV_N - 2) idle(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL req_run_busy: got %b want 1", busy); end
        checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL req_run_lo_early: got %h want 80000000", LO); end
        idle(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL req_run_done: got %b want 0", busy); end
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL req_run_lo: got %h want 0000000e", LO); end
        checks++; if (HI !== 32'd2) begin errors++; $display("FAIL req_run_hi: got %h want 00000002", HI); end
    endtask

    task automatic test_mthi_divzero();
        int nbusy;
        drive(1'b1, OP_MTHI, 32'h12345678, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", busy); end
        drive(1'b1, OP_DIV, 32'd55, 32'd0, 1'b0, 1'b0);
        nbusy = 0;
        repeat (DIV_N + 3) begin
            idle(1'b0);
            if (busy === 1'b1) nbusy++;
        end
        checks++; if (nbusy != DIV_N) begin errors++; $display("FAIL divzero_busy: got %0d cycles want %0d", nbusy, DIV_N); end
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL divzero_hi: got %h want 12345678", HI); end
        checks++; if (LO !== 32'd14) begin errors++; $display("FAIL divzero_lo: got %h want 0000000e", LO); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, OP_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
        repeat (3) idle(1'b1);
        checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL areset_pre_stall: got %b want 1", stall_md); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL areset_stall: got %b want 0", stall_md); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL areset_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL areset_lo: got %h want 0", LO); end
        reset = 1'b0;
        repeat (8) idle(1'b0);
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL areset_after_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL areset_after_lo: got %h want 0", LO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_after_busy: got %b want 0", busy); end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'($urandom_range(0, 20));
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic exp_busy;
        logic exp_stall;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            exp_busy  = (m_left != 0);
            exp_stall = exp_busy & E_md_use;
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, exp_busy); end
            checks++; if (stall_md !== exp_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, stall_md, exp_stall); end
            checks++; if (HI !== m_hi) begin errors++; $display("FAIL rand_hi[%0d]: got %h want %h", n, HI, m_hi); end
            checks++; if (LO !== m_lo) begin errors++; $display("FAIL rand_lo[%0d]: got %h want %h", n, LO, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu_stall();
        test_div_signed();
        test_req();
        test_mthi_divzero();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
